// File: rtl/sample_player_pkg.sv
// Shared definitions for the sample player: default widths and
// the playback FSM state encoding.
package sample_player_pkg;

    localparam int OUTPUT_WIDTH_DEF = 16;
    localparam int ADDR_WIDTH_DEF   = 12;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FETCH   = 2'd1,
        ST_PRESENT = 2'd2
    } state_t;

endpackage

// File: rtl/sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read
// port, read-before-write on an address collision.
// Ports: clk; wr_enable/wr_addr/wr_data write port;
//        rd_enable/rd_addr read request; rd_data registered result.
module sample_ram
    import sample_player_pkg::*;
#(
    parameter int DATA_WIDTH = OUTPUT_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  wr_enable,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_enable,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Both updates are non-blocking, so a same-cycle read of the
    // written address returns the old word.
    always_ff @(posedge clk) begin
        if (wr_enable) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_enable) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/sample_player.sv
// RAM-backed sample player: one sample per sample_tick, pointer
// advancing by step and wrapping inside [0, range].
// Ports: clk, reset (sync, active high); wr_enable/wr_addr/wr_data
//        RAM load; step, range, play, sample_tick playback control;
//        sample_out, sample_valid, overrun results.
// Macro SAMPLE_PLAYER_OFFSET_BINARY_EN: output MSB inverted
// (two's complement to offset binary).
module sample_player
    import sample_player_pkg::*;
#(
    parameter int OUTPUT_WIDTH = OUTPUT_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_enable,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [OUTPUT_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0]   step,
    input  logic [ADDR_WIDTH-1:0]   range,
    input  logic                    play,
    input  logic                    sample_tick,
    output logic [OUTPUT_WIDTH-1:0] sample_out,
    output logic                    sample_valid,
    output logic                    overrun
);

    localparam logic [ADDR_WIDTH:0] ONE = 1;

    state_t state;
    state_t state_nxt;

    logic                    accept;
    logic                    capture;
    logic                    busy;
    logic [ADDR_WIDTH-1:0]   rd_ptr;
    logic [ADDR_WIDTH-1:0]   ptr_nxt;
    logic [ADDR_WIDTH:0]     rng;
    logic [ADDR_WIDTH:0]     sum;
    logic [ADDR_WIDTH:0]     wrap;
    logic [OUTPUT_WIDTH-1:0] ram_q;
    logic [OUTPUT_WIDTH-1:0] ram_conv;

    sample_ram #(
        .DATA_WIDTH (OUTPUT_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk       (clk),
        .wr_enable (wr_enable),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_enable (accept),
        .rd_addr   (rd_ptr),
        .rd_data   (ram_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (sample_tick && play) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_FETCH:   state_nxt = ST_PRESENT;
            ST_PRESENT: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        accept  = 1'b0;
        capture = 1'b0;
        busy    = 1'b0;
        case (state)
            ST_IDLE:    accept  = sample_tick && play;
            ST_FETCH: begin
                capture = 1'b1;
                busy    = 1'b1;
            end
            ST_PRESENT: busy    = 1'b1;
            default:    busy    = 1'b0;
        endcase
    end

    // One wrap by (range+1); a step larger than the window that
    // still overshoots restarts from address 0.
    always_comb begin
        rng  = {1'b0, range};
        sum  = {1'b0, rd_ptr} + {1'b0, step};
        wrap = sum - rng - ONE;
        if (sum <= rng) begin
            ptr_nxt = sum[ADDR_WIDTH-1:0];
        end else if (wrap <= rng) begin
            ptr_nxt = wrap[ADDR_WIDTH-1:0];
        end else begin
            ptr_nxt = '0;
        end
    end

`ifdef SAMPLE_PLAYER_OFFSET_BINARY_EN
    assign ram_conv = {~ram_q[OUTPUT_WIDTH-1],
                       ram_q[OUTPUT_WIDTH-2:0]};
`else
    assign ram_conv = ram_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr       <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= capture;
            if (capture) begin
                sample_out <= ram_conv;
            end
            if (accept) begin
                rd_ptr <= ptr_nxt;
            end else if (!play) begin
                rd_ptr <= '0;
            end
            if (busy && sample_tick) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: doc/sample_player.md
SAMPLE_PLAYER -- requirements
Module: sample_player

Interface
REQ-001 SHALL have parameter OUTPUT_WIDTH, default 16, sample word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 12, sample RAM address width (depth 2^ADDR_WIDTH).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wr_enable  input  1  RAM write strobe.
REQ-006 SHALL have port wr_addr  input  ADDR_WIDTH  RAM write address.
REQ-007 SHALL have port wr_data  input  OUTPUT_WIDTH  RAM write data.
REQ-008 SHALL have port step  input  ADDR_WIDTH  read pointer increment per sample.
REQ-009 SHALL have port range  input  ADDR_WIDTH  last valid read address (inclusive).
REQ-010 SHALL have port play  input  1  playback enable level.
REQ-011 SHALL have port sample_tick  input  1  one-cycle sample-rate strobe.
REQ-012 SHALL have port sample_out  output  OUTPUT_WIDTH  registered output sample.
REQ-013 SHALL have port sample_valid  output  1  one-cycle pulse when sample_out updates.
REQ-014 SHALL have port overrun  output  1  sticky flag: sample_tick dropped.

Function
REQ-015 SHALL write wr_data to RAM[wr_addr] on any cycle with wr_enable=1, independent of play/state.
REQ-016 SHALL implement FSM IDLE -> FETCH -> PRESENT -> IDLE; IDLE->FETCH on sample_tick=1 and play=1; FETCH and PRESENT each last exactly one cycle.
REQ-017 SHALL in IDLE+tick issue RAM read at rd_ptr; in FETCH capture RAM data; in PRESENT drive sample_out and pulse sample_valid; latency tick-to-sample_valid = 2 cycles.
REQ-018 SHALL update rd_ptr on the IDLE->FETCH transition: sum = rd_ptr + step (ADDR_WIDTH+1 bits); if sum <= range next = sum; else next = sum - range - 1; if that result still > range, next = 0.
REQ-019 SHALL hold rd_ptr when step=0 (same sample repeated); range=0 SHALL read address 0 every sample.
REQ-020 SHALL drop sample_tick arriving in FETCH or PRESENT and set overrun=1 until reset.
REQ-021 SHALL, while play=0, force rd_ptr to 0 and stay/return to IDLE after completing any in-flight FETCH/PRESENT; sample_out holds last value.
REQ-022 SHALL return old RAM data on same-cycle read/write to the same address (read-before-write).
REQ-023 SHALL sample step and range only on the IDLE->FETCH transition; changes mid-sample take effect next tick.

Reset
REQ-024 SHALL on reset set state=IDLE, rd_ptr=0, sample_out=0, sample_valid=0, overrun=0; reset overrides all other inputs that cycle.
REQ-025 SHALL not clear RAM contents on reset; reset mid-FETCH/PRESENT SHALL abort without a sample_valid pulse.

Configuration
REQ-026 SHALL support macro SAMPLE_PLAYER_OFFSET_BINARY_EN: defined, sample_out = RAM data with MSB inverted (two's complement to offset binary for DAC), reset value 0 after inversion not applied (sample_out resets to 0); undefined, sample_out = RAM data unchanged.

Structure
REQ-027 SHALL place ADDR_WIDTH default, OUTPUT_WIDTH default and the FSM state encoding in shared package sample_player_pkg.
REQ-028 SHALL instantiate one sub-module sample_ram: simple dual-port, one write port, one registered read port, read-before-write.

Verification
REQ-029 SHALL cover: write RAM[0..3]=0x1111,0x2222,0x3333,0x4444; step=1, range=3, play=1, 6 ticks spaced 4 cycles -> samples 0x1111,0x2222,0x3333,0x4444,0x1111,0x2222, each sample_valid 2 cycles after tick.
REQ-030 SHALL cover: step=3, range=4, RAM[i]=i -> sample sequence 0,3,1,4,2,0.
REQ-031 SHALL cover: ticks on consecutive cycles -> second tick dropped, overrun=1 held until reset, no extra sample_valid.
REQ-032 SHALL cover: play deasserted after 2 samples then reasserted -> next sample from address 0; sample_out holds while play=0.
REQ-033 SHALL cover: reset asserted the cycle after tick -> no sample_valid, sample_out=0, rd_ptr=0; RAM contents unchanged on next reads.
REQ-034 SHALL cover: with SAMPLE_PLAYER_OFFSET_BINARY_EN, RAM data 0x8000 -> sample_out 0x0000, 0x7FFF -> 0xFFFF; without, unchanged.
